// File: rtl/mips_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : mips_pc_gen
// Purpose : Fetch-stage PC generator with priority redirect selection and a
//           circular return-address stack for call/return prediction.
// Revision: 1.0 - initial release
// ============================================================================
module mips_pc_gen #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] EXC_VEC   = 32'h80000180,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         PCWrite,
  input  logic                         exc_valid,
  input  logic                         br_valid,
  input  logic [PC_W-1:0]              br_target,
  input  logic                         jmp_valid,
  input  logic                         jmp_link,
  input  logic [PC_W-1:0]              jmp_target,
  input  logic                         ret_valid,
  output logic [PC_W-1:0]              PCout,
  output logic [PC_W-1:0]              PCnext,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  localparam int              AW     = $clog2(RAS_DEPTH);
  localparam int              CW     = AW + 1;
  localparam logic [PC_W-1:0] C_INC  = PC_W'(INC);
  localparam logic [CW-1:0]   C_FULL = CW'(RAS_DEPTH);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [AW-1:0]   r_top;
  logic [CW-1:0]   r_cnt;
  logic            r_uf;

  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_next;
  logic [AW-1:0]   w_top_inc;
  logic            w_ras_ne;
  logic            w_ret_sel;
  logic            w_upd;
  logic            w_norm;
  logic            w_push;
  logic            w_pop;
  logic            w_uf;

  assign w_seq     = r_pc + C_INC;
  assign w_top_inc = r_top + AW'(1);
  assign w_ras_ne  = (r_cnt != '0);
  assign w_ret_sel = ret_valid & w_ras_ne;
  assign w_upd     = exc_valid | br_valid | PCWrite;
  // RAS activity is only legal when no higher-priority redirect claims the cycle
  assign w_norm    = PCWrite & ~exc_valid & ~br_valid;
  assign w_pop     = w_norm & w_ret_sel;
  assign w_push    = w_norm & ~w_ret_sel & jmp_valid & jmp_link;
  assign w_uf      = w_norm & ret_valid & ~w_ras_ne;

  always_comb begin
    w_next = w_seq;
    if (exc_valid)      w_next = EXC_VEC;
    else if (br_valid)  w_next = br_target;
    else if (w_ret_sel) w_next = r_ras[r_top];
    else if (jmp_valid) w_next = jmp_target;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc  <= RESET_VEC;
      r_top <= '0;
      r_cnt <= '0;
      r_uf  <= 1'b0;
    end else begin
      if (w_upd) r_pc <= w_next;
      r_uf <= w_uf;
      if (exc_valid) begin
        r_cnt <= '0;
      end else if (w_pop) begin
        r_cnt <= r_cnt - CW'(1);
        r_top <= r_top - AW'(1);
      end else if (w_push) begin
        // When full, the slot above the top is the oldest entry and gets overwritten
        r_top <= w_top_inc;
        if (r_cnt != C_FULL) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && w_push) r_ras[w_top_inc] <= w_seq;
  end

  assign PCout         = r_pc;
  assign PCnext        = w_next;
  assign ras_count     = r_cnt;
  assign ras_underflow = r_uf;

endmodule
`default_nettype wire

// File: tb/tb_mips_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_pc_gen
// Purpose : Self-checking bench for mips_pc_gen (directed scenarios plus
//           randomized traffic against a queue-based reference model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_pc_gen;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        PCWrite = 1'b0, exc_valid = 1'b0, br_valid = 1'b0;
  logic        jmp_valid = 1'b0, jmp_link = 1'b0, ret_valid = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] PCout, PCnext;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  logic       p8_PCWrite = 1'b0, p8_exc = 1'b0, p8_br = 1'b0;
  logic [7:0] p8_br_target = '0;
  logic [7:0] p8_PCout, p8_PCnext;
  logic [2:0] p8_ras_count;
  logic       p8_uf;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_uf;
  logic [31:0] exp_next, obs_next;

  always #5 CLK = ~CLK;

  mips_pc_gen dut (
    .CLK(CLK), .RESET(RESET), .PCWrite(PCWrite), .exc_valid(exc_valid),
    .br_valid(br_valid), .br_target(br_target), .jmp_valid(jmp_valid),
    .jmp_link(jmp_link), .jmp_target(jmp_target), .ret_valid(ret_valid),
    .PCout(PCout), .PCnext(PCnext), .ras_count(ras_count),
    .ras_underflow(ras_underflow)
  );

  mips_pc_gen #(.PC_W(8), .RESET_VEC(8'h00), .EXC_VEC(8'h80)) dut8 (
    .CLK(CLK), .RESET(RESET), .PCWrite(p8_PCWrite), .exc_valid(p8_exc),
    .br_valid(p8_br), .br_target(p8_br_target), .jmp_valid(1'b0),
    .jmp_link(1'b0), .jmp_target(8'h00), .ret_valid(1'b0),
    .PCout(p8_PCout), .PCnext(p8_PCnext), .ras_count(p8_ras_count),
    .ras_underflow(p8_uf)
  );

  task automatic do_reset();
    RESET      = 1'b1;
    PCWrite    = 1'($urandom);
    exc_valid  = 1'($urandom);
    br_valid   = 1'($urandom);
    jmp_valid  = 1'($urandom);
    jmp_link   = 1'($urandom);
    ret_valid  = 1'($urandom);
    br_target  = $urandom;
    jmp_target = $urandom;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    m_pc = 32'h0;
    m_q.delete();
    m_uf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model from the architectural rules
  task automatic cyc(input logic pw, input logic ex, input logic bv, input logic [31:0] bt,
                     input logic jv, input logic jl, input logic [31:0] jt, input logic rv);
    logic upd, ret_ok;
    PCWrite = pw; exc_valid = ex; br_valid = bv; br_target = bt;
    jmp_valid = jv; jmp_link = jl; jmp_target = jt; ret_valid = rv;
    #1;
    obs_next = PCnext;
    ret_ok = rv && (m_q.size() != 0);
    if (ex)          exp_next = 32'h80000180;
    else if (bv)     exp_next = bt;
    else if (ret_ok) exp_next = m_q[$];
    else if (jv)     exp_next = jt;
    else             exp_next = m_pc + 32'd4;
    upd  = ex || bv || pw;
    m_uf = pw && !ex && !bv && rv && (m_q.size() == 0);
    if (ex) m_q.delete();
    else if (pw && !bv) begin
      if (ret_ok) void'(m_q.pop_back());
      else if (jv && jl) begin
        m_q.push_back(m_pc + 32'd4);
        if (m_q.size() > 4) void'(m_q.pop_front());
      end
    end
    if (upd) m_pc = exp_next;
    @(posedge CLK);
    #1;
  endtask

  task automatic seq_step();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (PCout !== 32'h0) $display("FAIL reset_pc actual=%h required=%h", PCout, 32'h0);
    else n_pass++;
    n_total++;
    if (ras_count !== 3'd0) $display("FAIL reset_count actual=%0d required=0", ras_count);
    else n_pass++;
    n_total++;
    if (ras_underflow !== 1'b0) $display("FAIL reset_uf actual=%b required=0", ras_underflow);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] req;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      seq_step();
      req = 32'(i * 4);
      n_total++;
      if (PCout !== req) $display("FAIL seq_pc%0d actual=%h required=%h", i, PCout, req);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] req [3] = '{32'h10, 32'h10, 32'h14};
    logic        pw  [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) seq_step();
    for (int i = 0; i < 3; i++) begin
      cyc(pw[i], 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      n_total++;
      if (PCout !== req[i]) $display("FAIL stall_pc%0d actual=%h required=%h", i, PCout, req[i]);
      else n_pass++;
    end
  endtask

  task automatic test_call_return();
    do_reset();
    for (int i = 0; i < 8; i++) seq_step();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0);
    n_total++;
    if (PCout !== 32'h100 || ras_count !== 3'd1)
      $display("FAIL call pc=%h cnt=%0d required pc=00000100 cnt=1", PCout, ras_count);
    else n_pass++;
    seq_step();
    // ret and jump together: return wins, no push
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1);
    n_total++;
    if (PCout !== 32'h24 || ras_count !== 3'd0)
      $display("FAIL ret pc=%h cnt=%0d required pc=00000024 cnt=0", PCout, ras_count);
    else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] ra [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 32'h1000), 1'b0);
    n_total++;
    if (ras_count !== 3'd4) $display("FAIL ovf_count actual=%0d required=4", ras_count);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      n_total++;
      if (PCout !== ra[i]) $display("FAIL lifo%0d actual=%h required=%h", i, PCout, ra[i]);
      else n_pass++;
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if (ras_underflow !== 1'b1 || PCout !== 32'h1008 || ras_count !== 3'd0)
      $display("FAIL underflow uf=%b pc=%h cnt=%0d required uf=1 pc=00001008 cnt=0",
               ras_underflow, PCout, ras_count);
    else n_pass++;
    seq_step();
    n_total++;
    if (ras_underflow !== 1'b0) $display("FAIL uf_pulse actual=%b required=0", ras_underflow);
    else n_pass++;
  endtask

  task automatic test_exception();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h600, 1'b1);
    n_total++;
    if (obs_next !== 32'h80000180) $display("FAIL exc_pcnext actual=%h required=80000180", obs_next);
    else n_pass++;
    n_total++;
    if (PCout !== 32'h80000180 || ras_count !== 3'd0)
      $display("FAIL exc pc=%h cnt=%0d required pc=80000180 cnt=0", PCout, ras_count);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0), ($urandom_range(7, 0) == 0),
          {$urandom_range(255, 0), 2'b00}, ($urandom_range(2, 0) == 0), 1'($urandom),
          {$urandom_range(255, 0), 2'b00}, ($urandom_range(2, 0) == 0));
      n_total++;
      if (obs_next !== exp_next) begin
        if (errs++ < 10) $display("FAIL rnd_pcnext cyc=%0d actual=%h required=%h", i, obs_next, exp_next);
      end else n_pass++;
      n_total++;
      if (PCout !== m_pc) begin
        if (errs++ < 10) $display("FAIL rnd_pc cyc=%0d actual=%h required=%h", i, PCout, m_pc);
      end else n_pass++;
      n_total++;
      if (ras_count !== 3'(m_q.size())) begin
        if (errs++ < 10) $display("FAIL rnd_count cyc=%0d actual=%0d required=%0d", i, ras_count, m_q.size());
      end else n_pass++;
      n_total++;
      if (ras_underflow !== m_uf) begin
        if (errs++ < 10) $display("FAIL rnd_uf cyc=%0d actual=%b required=%b", i, ras_underflow, m_uf);
      end else n_pass++;
    end
  endtask

  task automatic test_wrap8();
    do_reset();
    PCWrite = 1'b0; exc_valid = 1'b0; br_valid = 1'b0;
    jmp_valid = 1'b0; jmp_link = 1'b0; ret_valid = 1'b0;
    p8_PCWrite = 1'b0; p8_br = 1'b1; p8_br_target = 8'hFC;
    @(posedge CLK); #1;
    n_total++;
    if (p8_PCout !== 8'hFC) $display("FAIL w8_setup actual=%h required=fc", p8_PCout);
    else n_pass++;
    p8_PCWrite = 1'b1; p8_br = 1'b0;
    @(posedge CLK); #1;
    n_total++;
    if (p8_PCout !== 8'h00) $display("FAIL w8_wrap actual=%h required=00", p8_PCout);
    else n_pass++;
    p8_PCWrite = 1'b0; p8_br = 1'b1; p8_br_target = 8'h40;
    @(posedge CLK); #1;
    n_total++;
    if (p8_PCout !== 8'h40) $display("FAIL w8_branch actual=%h required=40", p8_PCout);
    else n_pass++;
    p8_br = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_call_return();
    test_ras_overflow();
    test_exception();
    test_random();
    test_wrap8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
